imu_frame_assembler: RTL and testbench
======================================

# imu_frame_assembler

Assembles the IMU burst-read byte stream (14 bytes, big-endian, accel X/Y/Z, temperature, gyro X/Y/Z) into the five signed 16-bit raw words consumed by the preprocessor. It sits directly upstream of `preprocessor` and drives its RAW_* inputs and TVALID. It honours a TREADY back-pressure input, discards the temperature and gyro-Z fields, and detects and drops malformed frames.

## Interface
- FRAME_BYTES, 14: bytes per burst; fixed, not to be overridden.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- S_TDATA  in  8  byte from SPI burst engine
- S_TVALID  in  1  byte valid
- S_TLAST  in  1  marks final byte of a burst
- S_TREADY  out  1  byte accepted when S_TVALID && S_TREADY at posedge
- RAW_ACCL_X / RAW_ACCL_Y / RAW_ACCL_Z  out  16 signed  int16 accel words
- RAW_GYRO_X / RAW_GYRO_Y  out  16 signed  int16 gyro words
- TVALID  out  1  output words valid
- TREADY  in  1  downstream accepts when TVALID && TREADY at posedge
- FRAME_ERR  out  1  one-cycle pulse per malformed frame
- ERR_COUNT  out  8  malformed-frame count, saturates at 255

## Operation
- Byte index k runs 0..13. Each word is formed as {hi, lo}: hi is at the even index and lo at the odd index.
- Byte map:
  - 0–1: ACCL_X
  - 2–3: ACCL_Y
  - 4–5: ACCL_Z
  - 6–7: temperature (dropped)
  - 8–9: GYRO_X
  - 10–11: GYRO_Y
  - 12–13: GYRO_Z (dropped)
- Kept words go into staging registers. Output registers are separate from staging.
- State COLLECT:
  - Accepted byte with k<13 and S_TLAST=0: store the byte and increment k.
  - Accepted byte with k<13 and S_TLAST=1 (short frame): set k=0, discard staging, pulse FRAME_ERR, increment ERR_COUNT. No publish.
  - Accepted byte with k==13 and S_TLAST=1: publish. Output registers load from staging, and TVALID is set. Then k=0.
  - Accepted byte with k==13 and S_TLAST=0 (long frame): pulse FRAME_ERR, increment ERR_COUNT, go to DISCARD. No publish.
- State DISCARD:
  - Every byte is accepted and dropped.
  - An accepted byte with S_TLAST=1 sets k=0 and returns to COLLECT.
  - No further error is counted for the same frame.
- Back-pressure:
  - S_TREADY = !reset && !(state==COLLECT && k==13 && TVALID && !TREADY).
  - Only the publishing byte stalls. Bytes 0..12 are always accepted, and staging is independent of the outputs.
- TVALID is cleared on TVALID && TREADY, unless a publish happens in the same cycle. In that case the new words load and TVALID stays 1.
- Output words are held stable while TVALID && !TREADY.
- ERR_COUNT saturates at 255 and never wraps.
- Reset values:
  - All RAW_* = 0, TVALID = 0, FRAME_ERR = 0, ERR_COUNT = 0.
  - k = 0, state = COLLECT, staging = 0.
  - S_TREADY = 0 while reset is high.
- Reset mid-frame abandons the partial frame with no error count. The next accepted byte is treated as index 0.

## Timing
- Publish latency: if the final byte is accepted at posedge N, the RAW_* words are updated and TVALID = 1 from posedge N onward. The preprocessor can capture them at posedge N+1.
- Maximum throughput is one frame per 14 cycles with no bubbles when TREADY is held high.
- FRAME_ERR is high for exactly the one cycle following the posedge that accepted the offending byte.
- S_TREADY is combinational on TVALID, TREADY, k and state, with no combinational path from S_TDATA.

## Test plan
- Single frame, bytes 0x01..0x0E, TREADY=1:
  - Required words: ACCL_X=0x0102, ACCL_Y=0x0304, ACCL_Z=0x0506, GYRO_X=0x090A, GYRO_Y=0x0B0C.
  - TVALID is high for exactly 1 cycle.
- Negative values: ACCL_Z bytes 0xFF,0x38 → RAW_ACCL_Z = −200; GYRO_X bytes 0x80,0x00 → −32768.
- Back-to-back frames with TREADY=0 until 5 cycles after the second frame's byte 13 is presented:
  - S_TREADY stays low on byte 13 only.
  - First-frame words are held.
  - When TREADY=1, the second frame loads in the same cycle and TVALID stays 1.
- Error frames:
  - Short frame, S_TLAST on byte 9: FRAME_ERR pulses, ERR_COUNT=1, outputs unchanged, and the next 14-byte frame publishes correctly.
  - Long frame of 17 bytes: one FRAME_ERR, ERR_COUNT increments by 1, bytes up to S_TLAST are dropped, and the following frame is correct.
- Reset and saturation:
  - Reset asserted after byte 6: all outputs are 0, S_TREADY=0 during reset, and a fresh frame afterwards assembles correctly.
  - 300 short frames: ERR_COUNT stops at 255.

Source files
------------

// File: rtl/imu_frame_assembler.sv
// Assembles the 14-byte big-endian IMU burst into five signed 16-bit words.
// Temperature and gyro-Z are dropped; short and long frames are counted and discarded.
module imu_frame_assembler (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         S_TDATA,
    input  logic               S_TVALID,
    input  logic               S_TLAST,
    output logic               S_TREADY,
    output logic signed [15:0] RAW_ACCL_X,
    output logic signed [15:0] RAW_ACCL_Y,
    output logic signed [15:0] RAW_ACCL_Z,
    output logic signed [15:0] RAW_GYRO_X,
    output logic signed [15:0] RAW_GYRO_Y,
    output logic               TVALID,
    input  logic               TREADY,
    output logic               FRAME_ERR,
    output logic [7:0]         ERR_COUNT
);

    localparam int         FRAME_BYTES = 14;
    localparam logic [3:0] LAST_IDX    = 4'(FRAME_BYTES - 1);

    typedef enum logic {COLLECT, DISCARD} state_t;

    state_t             state, state_next;
    logic [3:0]         k;
    logic signed [15:0] stg_ax, stg_ay, stg_az, stg_gx, stg_gy;
    logic               accept, at_last;
    logic               do_store, do_publish, do_err, do_rewind;

    // Only the publishing byte can stall, and only while the previous words are unconsumed.
    assign S_TREADY = !reset && !(state == COLLECT && k == LAST_IDX && TVALID && !TREADY);
    assign accept   = S_TVALID && S_TREADY;
    assign at_last  = (k == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && at_last && !S_TLAST) state_next = DISCARD;
            DISCARD: if (accept && S_TLAST)             state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        do_store   = 1'b0;
        do_publish = 1'b0;
        do_err     = 1'b0;
        do_rewind  = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (!at_last) begin
                        if (S_TLAST) begin
                            do_err    = 1'b1;
                            do_rewind = 1'b1;
                        end else begin
                            do_store  = 1'b1;
                        end
                    end else if (S_TLAST) begin
                        do_publish = 1'b1;
                        do_rewind  = 1'b1;
                    end else begin
                        do_err = 1'b1;
                    end
                end
            end
            DISCARD: if (accept && S_TLAST) do_rewind = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)          k <= '0;
        else if (do_rewind) k <= '0;
        else if (do_store)  k <= k + 4'd1;
    end

    // Bytes 6, 7 and 12 are accepted but never stored.
    always_ff @(posedge clk) begin
        if (reset || do_err) begin
            stg_ax <= '0;
            stg_ay <= '0;
            stg_az <= '0;
            stg_gx <= '0;
            stg_gy <= '0;
        end else if (do_store) begin
            case (k)
                4'd0:  stg_ax[15:8] <= S_TDATA;
                4'd1:  stg_ax[7:0]  <= S_TDATA;
                4'd2:  stg_ay[15:8] <= S_TDATA;
                4'd3:  stg_ay[7:0]  <= S_TDATA;
                4'd4:  stg_az[15:8] <= S_TDATA;
                4'd5:  stg_az[7:0]  <= S_TDATA;
                4'd8:  stg_gx[15:8] <= S_TDATA;
                4'd9:  stg_gx[7:0]  <= S_TDATA;
                4'd10: stg_gy[15:8] <= S_TDATA;
                4'd11: stg_gy[7:0]  <= S_TDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RAW_ACCL_X <= '0;
            RAW_ACCL_Y <= '0;
            RAW_ACCL_Z <= '0;
            RAW_GYRO_X <= '0;
            RAW_GYRO_Y <= '0;
            TVALID     <= 1'b0;
        end else if (do_publish) begin
            RAW_ACCL_X <= stg_ax;
            RAW_ACCL_Y <= stg_ay;
            RAW_ACCL_Z <= stg_az;
            RAW_GYRO_X <= stg_gx;
            RAW_GYRO_Y <= stg_gy;
            TVALID     <= 1'b1;
        end else if (TVALID && TREADY) begin
            TVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            FRAME_ERR <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            FRAME_ERR <= do_err;
            if (do_err && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Bench for imu_frame_assembler: table vectors, hand-written corner sequences,
// and random frames against a frame-level reference model.
module tb_imu_frame_assembler;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  b[14];
        logic [79:0] w;
    } vec_t;

    logic               clk, reset;
    logic [7:0]         S_TDATA;
    logic               S_TVALID, S_TLAST, S_TREADY;
    logic signed [15:0] RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, RAW_GYRO_X, RAW_GYRO_Y;
    logic               TVALID, TREADY, FRAME_ERR;
    logic [7:0]         ERR_COUNT;
    logic [79:0]        words;

    int          n_checks = 0, n_fail = 0;
    int          err_total = 0, err_since_rst = 0, err_pulses = 0;
    bit          rnd_rdy = 0, hold_prev = 0;
    logic [79:0] prev_words;
    logic [79:0] exp_q[$], rx_q[$];
    vec_t        tbl[4];

    imu_frame_assembler dut (
        .clk(clk), .reset(reset),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
        .RAW_ACCL_X(RAW_ACCL_X), .RAW_ACCL_Y(RAW_ACCL_Y), .RAW_ACCL_Z(RAW_ACCL_Z),
        .RAW_GYRO_X(RAW_GYRO_X), .RAW_GYRO_Y(RAW_GYRO_Y),
        .TVALID(TVALID), .TREADY(TREADY), .FRAME_ERR(FRAME_ERR), .ERR_COUNT(ERR_COUNT)
    );

    assign words = {RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, RAW_GYRO_X, RAW_GYRO_Y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshakes, hold stability and error pulses observed mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check("hold_tvalid", 80'(TVALID), 80'd1);
                check("hold_words", words, prev_words);
            end
            if (TVALID && TREADY) rx_q.push_back(words);
            if (FRAME_ERR) err_pulses++;
            hold_prev  = TVALID && !TREADY;
            prev_words = words;
        end
    end

    function automatic logic [79:0] words_of(input bq_t f);
        return {f[0], f[1], f[2], f[3], f[4], f[5], f[8], f[9], f[10], f[11]};
    endfunction

    // A frame is good only if it is exactly 14 bytes long.
    task automatic model_frame(input bq_t f);
        if (f.size() == 14) exp_q.push_back(words_of(f));
        else begin
            err_total++;
            err_since_rst++;
        end
    endtask

    function automatic logic [79:0] exp_err_count();
        return 80'((err_since_rst > 255) ? 255 : err_since_rst);
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        S_TDATA = d; S_TVALID = 1'b1; S_TLAST = l;
        #1;
        while (!S_TREADY && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (rnd_rdy && n > 3) TREADY = 1'b1;
            #1;
        end
        if (!S_TREADY) check("s_tready_timeout", 80'd0, 80'd1);
        @(posedge clk); #1;
        S_TVALID = 1'b0; S_TLAST = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input bit use_model);
        for (int i = 0; i < f.size(); i++) begin
            if (rnd_rdy) TREADY = ($urandom % 3) != 0;
            send_byte(f[i], i == f.size() - 1);
        end
        if (use_model) model_frame(f);
    endtask

    task automatic drain();
        int n = 0;
        TREADY = 1'b1;
        while (rx_q.size() < exp_q.size() && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_count", 80'(rx_q.size()), 80'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0)
            check("frame_words", rx_q.pop_front(), exp_q.pop_front());
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bq_t f, fa, fb;
        int  vcnt, p0, e0;
        logic [79:0] held;

        tbl[0].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                     8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
        tbl[0].w = {16'h0102, 16'h0304, 16'h0506, 16'h090A, 16'h0B0C};
        tbl[1].b = '{8'h00, 8'h10, 8'h00, 8'h20, 8'hFF, 8'h38, 8'h12,
                     8'h34, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h56, 8'h78};
        tbl[1].w = {16'h0010, 16'h0020, 16'hFF38, 16'h8000, 16'h7FFF};
        tbl[2].b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
                     8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        tbl[2].w = {16'h1234, 16'h5678, 16'h9ABC, 16'h1122, 16'h3344};
        tbl[3].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[3].w = {80{1'b1}};

        reset = 1'b1; S_TDATA = '0; S_TVALID = 1'b0; S_TLAST = 1'b0; TREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_words", words, 80'd0);
        check("rst_tvalid", 80'(TVALID), 80'd0);
        check("rst_frame_err", 80'(FRAME_ERR), 80'd0);
        check("rst_err_count", 80'(ERR_COUNT), 80'd0);
        check("rst_s_tready", 80'(S_TREADY), 80'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single frame: publish latency and a one-cycle TVALID.
        TREADY = 1'b1;
        f = {};
        for (int i = 0; i < 14; i++) f.push_back(8'(i + 1));
        send_frame(f, 1'b1);
        check("publish_latency", 80'(TVALID), 80'd1);
        check("publish_words", words, tbl[0].w);
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (TVALID) vcnt++;
        end
        check("tvalid_one_cycle", 80'(vcnt), 80'd1);
        drain();

        for (int i = 0; i < 4; i++) begin
            f = {};
            for (int j = 0; j < 14; j++) f.push_back(tbl[i].b[j]);
            exp_q.push_back(tbl[i].w);
            send_frame(f, 1'b0);
            drain();
            check("table_hold", words, tbl[i].w);
            if (i == 1) begin
                check("neg_accl_z", 80'(int'(RAW_ACCL_Z)), 80'(-200));
                check("neg_gyro_x", 80'(int'(RAW_GYRO_X)), 80'(-32768));
            end
        end

        // Back-to-back frames under back-pressure: only byte 13 of frame B stalls.
        TREADY = 1'b0;
        fa = {}; fb = {};
        for (int i = 0; i < 14; i++) begin
            fa.push_back(8'(8'h20 + i));
            fb.push_back(8'(8'h40 + i));
        end
        send_frame(fa, 1'b1);
        for (int i = 0; i < 13; i++) send_byte(fb[i], 1'b0);
        S_TDATA = fb[13]; S_TVALID = 1'b1; S_TLAST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stall", 80'(S_TREADY), 80'd0);
            check("bp_hold_a", words, words_of(fa));
        end
        @(posedge clk); #1;
        TREADY = 1'b1;
        #1;
        check("bp_release", 80'(S_TREADY), 80'd1);
        @(posedge clk); #1;
        S_TVALID = 1'b0; S_TLAST = 1'b0;
        check("bp_tvalid_kept", 80'(TVALID), 80'd1);
        check("bp_words_b", words, words_of(fb));
        model_frame(fb);
        drain();

        // Short frame: last on byte index 8.
        held = words;
        f = {};
        for (int i = 0; i < 9; i++) f.push_back(8'(8'hA0 + i));
        send_frame(f, 1'b1);
        check("short_pulse", 80'(FRAME_ERR), 80'd1);
        check("short_count", 80'(ERR_COUNT), exp_err_count());
        @(posedge clk); #1;
        check("short_pulse_end", 80'(FRAME_ERR), 80'd0);
        check("short_no_publish", words, held);
        check("short_tvalid", 80'(TVALID), 80'd0);
        f = {};
        for (int i = 0; i < 14; i++) f.push_back(8'(8'hC0 + i));
        send_frame(f, 1'b1);
        drain();

        // Long frame of 17 bytes.
        p0 = err_pulses;
        e0 = int'(ERR_COUNT);
        f = {};
        for (int i = 0; i < 17; i++) f.push_back(8'(8'h60 + i));
        send_frame(f, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("long_pulses", 80'(err_pulses - p0), 80'd1);
        check("long_count", 80'(ERR_COUNT), 80'(e0 + 1));
        f = {};
        for (int i = 0; i < 14; i++) f.push_back(8'(8'hE0 + i));
        send_frame(f, 1'b1);
        drain();

        // Random frames with random back-pressure.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r, len;
            r = $urandom % 6;
            len = (r == 0) ? $urandom_range(1, 13) : (r == 1) ? $urandom_range(15, 20) : 14;
            f = {};
            for (int i = 0; i < len; i++) f.push_back(8'($urandom));
            send_frame(f, 1'b1);
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_rdy = 1'b0;
        drain();
        check("rand_err_count", 80'(ERR_COUNT), exp_err_count());
        check("rand_err_pulses", 80'(err_pulses), 80'(err_total));

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send_byte(8'(8'h90 + i), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_s_tready", 80'(S_TREADY), 80'd0);
        check("midrst_words", words, 80'd0);
        check("midrst_tvalid", 80'(TVALID), 80'd0);
        check("midrst_err_count", 80'(ERR_COUNT), 80'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        err_since_rst = 0;
        @(posedge clk); #1;
        f = {};
        for (int i = 0; i < 14; i++) f.push_back(8'(8'h30 + 3 * i));
        send_frame(f, 1'b1);
        drain();
        check("post_rst_err_count", 80'(ERR_COUNT), 80'd0);

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            f = {8'(n)};
            send_frame(f, 1'b1);
            if (n == 199) check("sat_mid", 80'(ERR_COUNT), exp_err_count());
        end
        repeat (2) @(posedge clk);
        #1;
        check("sat_count", 80'(ERR_COUNT), 80'd255);
        check("sat_pulses", 80'(err_pulses), 80'(err_total));
        f = {};
        for (int i = 0; i < 14; i++) f.push_back(8'(8'h05 * i));
        send_frame(f, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
